// File: rtl/rb_read_arbiter.sv
// rb_read_arbiter: round-robin/locking arbiter sharing BRAM read port B.
// Ports: req_valid/req_lock/req_addr/req_ready per requester; en_b/addr_b/dout_b
// to the BRAM; rsp_valid/rsp_data tagged responses; owner/locked lock status.
// Optional macro RB_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins).
module rb_read_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_lock,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      en_b,
  output logic [ADDR_W-1:0]         addr_b,
  input  logic [DATA_W-1:0]         dout_b,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [$clog2(N_REQ)-1:0]  owner,
  output logic                      locked
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic {
    S_ARB,
    S_LOCKED
  } state_t;

  state_t            state;
  logic [N_REQ-1:0]  gnt;
  logic [IW-1:0]     gidx;
  logic [IW-1:0]     scan_idx;
  logic              found;
  logic [ADDR_W-1:0] sel_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [N_REQ-1:0]  tag [RD_LAT];

`ifndef RB_ARB_FIXED_PRIO_EN
  logic [IW-1:0]     ptr;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction
`endif

  // Grant is gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    gnt      = '0;
    gidx     = '0;
    scan_idx = '0;
    found    = 1'b0;
    if (rst_n) begin
      unique case (state)
        S_LOCKED: begin
          if (req_valid[owner]) begin
            gnt[owner] = 1'b1;
            gidx       = owner;
          end
        end
        S_ARB: begin
          for (int k = 0; k < N_REQ; k++) begin
`ifdef RB_ARB_FIXED_PRIO_EN
            scan_idx = IW'(k);
`else
            scan_idx = IW'((int'(ptr) + k) % N_REQ);
`endif
            if (!found && req_valid[scan_idx]) begin
              found         = 1'b1;
              gnt[scan_idx] = 1'b1;
              gidx          = scan_idx;
            end
          end
        end
      endcase
    end
  end

  assign sel_addr  = req_addr[int'(gidx)*ADDR_W +: ADDR_W];
  assign req_ready = gnt;
  assign en_b      = |gnt;
  assign addr_b    = en_b ? sel_addr : last_addr;
  assign locked    = (state == S_LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_ARB;
      owner     <= '0;
      last_addr <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      for (int k = 0; k < RD_LAT; k++) tag[k] <= '0;
`ifndef RB_ARB_FIXED_PRIO_EN
      ptr       <= '0;
`endif
    end else begin
      tag[0] <= gnt;
      for (int k = 1; k < RD_LAT; k++) tag[k] <= tag[k-1];
      rsp_valid <= tag[RD_LAT-1];
      if (|tag[RD_LAT-1]) rsp_data <= dout_b;
      if (en_b) begin
        last_addr <= sel_addr;
        unique case (state)
          S_ARB: begin
`ifndef RB_ARB_FIXED_PRIO_EN
            ptr <= wrap_inc(gidx);
`endif
            if (req_lock[gidx]) begin
              state <= S_LOCKED;
              owner <= gidx;
            end
          end
          S_LOCKED: begin
            if (!req_lock[gidx]) begin
              state <= S_ARB;
`ifndef RB_ARB_FIXED_PRIO_EN
              ptr   <= wrap_inc(owner);
`endif
            end
          end
        endcase
      end
    end
  end

endmodule
